// File: rtl/dbg_trace_pkg.sv
// Shared definitions for the branch-trace drain controller: register map,
// trace status encodings, ctrl bit layout and FSM state types.
package dbg_trace_pkg;

    localparam logic [31:0] REG_REGION = 32'h0001_0000;
    localparam logic [31:0] OFS_CTRL   = 32'h0000_0000;
    localparam logic [31:0] OFS_START  = 32'h0000_0004;
    localparam logic [31:0] OFS_END    = 32'h0000_0008;
    localparam logic [31:0] OFS_STATUS = 32'h0000_000C;
    localparam logic [31:0] OFS_WPTR   = 32'h0000_0010;

    typedef enum logic [2:0] {
        TS_IDLE = 3'd0,
        TS_WAIT = 3'd1,
        TS_RUN  = 3'd2,
        TS_DONE = 3'd3,
        TS_EOB  = 3'd4
    } trace_status_e;

    localparam int unsigned CTRL_EN_BIT   = 31;
    localparam int unsigned CTRL_WRAP_BIT = 16;
    localparam int unsigned CTRL_MODE_MSB = 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG_START,
        S_CFG_END,
        S_CFG_CTRL,
        S_POLL_WAIT,
        S_POLL_RD,
        S_RD_PTR,
        S_RD_LO,
        S_RD_HI,
        S_PUSH,
        S_DISABLE
    } drain_state_e;

    typedef enum logic [1:0] {
        AM_IDLE,
        AM_SETUP,
        AM_ACCESS,
        AM_DROP
    } apb_state_e;

    function automatic logic [31:0] ctrl_word(input logic [2:0] mode, input logic wrap);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN_BIT]       = 1'b1;
        w[CTRL_WRAP_BIT]     = wrap;
        w[CTRL_MODE_MSB:0]   = mode;
        return w;
    endfunction

endpackage

// File: rtl/dbg_apb_master_if.sv
// Single-transfer APB master: one request in, one completion pulse out.
// DBG_TRACE_DRAIN_TIMEOUT_EN enables the ACCESS-phase timeout.
module dbg_apb_master_if
    import dbg_trace_pkg::*;
#(
    parameter int unsigned APB_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [47:0] wdata,
    output logic        ack,
    output logic        slverr,
    output logic        tmo,
    output logic [47:0] rdata,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [47:0] pwdata,
    input  logic [47:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

`ifdef DBG_TRACE_DRAIN_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int unsigned CW = ($clog2(APB_TIMEOUT + 1) > 8) ? $clog2(APB_TIMEOUT + 1) : 8;

    apb_state_e  state_q, state_d;
    logic [CW-1:0] tmo_cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= AM_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            AM_IDLE:   if (req) state_d = AM_SETUP;
            AM_SETUP:  state_d = AM_ACCESS;
            AM_ACCESS: begin
                if (pready)   state_d = AM_IDLE;
                else if (tmo) state_d = AM_DROP;
            end
            AM_DROP:   state_d = AM_IDLE;
            default:   state_d = AM_IDLE;
        endcase
    end

    always_comb begin
        psel    = (state_q == AM_SETUP) || (state_q == AM_ACCESS);
        penable = (state_q == AM_ACCESS);
        ack     = (state_q == AM_ACCESS) && pready;
        slverr  = ack && pslverr;
        rdata   = prdata;
        tmo     = TMO_EN && (state_q == AM_ACCESS) && !pready
                  && (tmo_cnt_q == CW'(APB_TIMEOUT - 1));
    end

    // Address/data are latched when the request is taken so they stay stable
    // through completion regardless of what the requester does afterwards.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            tmo_cnt_q <= '0;
        end else begin
            if (state_q == AM_IDLE && req) begin
                pwrite <= wr;
                paddr  <= addr;
                pwdata <= wdata;
            end
            if (TMO_EN && state_q == AM_ACCESS && !pready) tmo_cnt_q <= tmo_cnt_q + 1'b1;
            else                                          tmo_cnt_q <= '0;
        end
    end

endmodule

// File: rtl/dbg_trace_drain_ctrl.sv
// APB sequencer that configures the branch-trace unit, waits for capture end
// and drains its RAM as 80-bit beats. Optional macro: DBG_TRACE_DRAIN_TIMEOUT_EN.
module dbg_trace_drain_ctrl
    import dbg_trace_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int unsigned TRACE_WORDS   = 1024,
    parameter int unsigned POLL_INTERVAL = 16,
    parameter int unsigned APB_TIMEOUT   = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic [2:0]  mode_i,
    input  logic        wrap_en_i,
    input  logic [31:0] addr_start_i,
    input  logic [31:0] addr_end_i,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] paddr_o,
    output logic [47:0] pwdata_o,
    input  logic [47:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i,
    output logic        out_valid_o,
    output logic [79:0] out_data_o,
    input  logic        out_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        wrapped_o
);

    localparam int unsigned TRACE_WIDTH = $clog2(TRACE_WORDS);
    localparam int unsigned PW          = $clog2(POLL_INTERVAL + 1);
    localparam logic [31:0] REG_BASE    = BASE_ADDR + REG_REGION;

    drain_state_e         state_q, state_d;
    logic [2:0]           mode_q;
    logic                 wrap_en_q, stop_pend_q, wrap_flag_q;
    logic [31:0]          addr_start_q, addr_end_q;
    logic [PW-1:0]        poll_cnt_q;
    logic [TRACE_WIDTH-1:0] idx_q;
    logic [TRACE_WIDTH:0] rem_q, n_entries;
    logic [47:0]          lo_q;
    logic [31:0]          hi_q, ram_ofs;

    logic        req, wr, ack, slverr, tmo;
    logic [31:0] addr;
    logic [47:0] wdata, rdata;

    dbg_apb_master_if #(
        .APB_TIMEOUT (APB_TIMEOUT)
    ) u_apb (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .req     (req),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .ack     (ack),
        .slverr  (slverr),
        .tmo     (tmo),
        .rdata   (rdata),
        .psel    (psel_o),
        .penable (penable_o),
        .pwrite  (pwrite_o),
        .paddr   (paddr_o),
        .pwdata  (pwdata_o),
        .prdata  (prdata_i),
        .pready  (pready_i),
        .pslverr (pslverr_i)
    );

    assign n_entries = wrap_flag_q ? (TRACE_WIDTH + 1)'(TRACE_WORDS)
                                   : {1'b0, rdata[TRACE_WIDTH-1:0]};
    assign ram_ofs   = 32'(idx_q) << 3;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start_i) state_d = S_CFG_START;
            S_CFG_START: if (ack) state_d = S_CFG_END;
            S_CFG_END:   if (ack) state_d = S_CFG_CTRL;
            S_CFG_CTRL:  if (ack) state_d = S_POLL_WAIT;
            S_POLL_WAIT: begin
                if (stop_i)                                     state_d = S_RD_PTR;
                else if (poll_cnt_q == PW'(POLL_INTERVAL - 1)) state_d = S_POLL_RD;
            end
            S_POLL_RD: if (ack) begin
                if (stop_i || stop_pend_q || rdata[2:0] == TS_DONE || rdata[2:0] == TS_EOB)
                    state_d = S_RD_PTR;
                else
                    state_d = S_POLL_WAIT;
            end
            S_RD_PTR:  if (ack) state_d = (n_entries == '0) ? S_DISABLE : S_RD_LO;
            S_RD_LO:   if (ack) state_d = S_RD_HI;
            S_RD_HI:   if (ack) state_d = S_PUSH;
            S_PUSH:    if (out_ready_i)
                           state_d = (rem_q == (TRACE_WIDTH + 1)'(1)) ? S_DISABLE : S_RD_LO;
            S_DISABLE: if (ack) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // Error/timeout override the per-state decision; DISABLE errors fall through to IDLE.
        if (slverr && state_q != S_DISABLE) state_d = S_DISABLE;
        if (tmo)                            state_d = S_IDLE;
    end

    always_comb begin
        req   = 1'b0;
        wr    = 1'b0;
        addr  = REG_BASE;
        wdata = '0;
        case (state_q)
            S_CFG_START: begin req = 1'b1; wr = 1'b1; addr = REG_BASE + OFS_START; wdata = {16'h0, addr_start_q}; end
            S_CFG_END:   begin req = 1'b1; wr = 1'b1; addr = REG_BASE + OFS_END;   wdata = {16'h0, addr_end_q}; end
            S_CFG_CTRL:  begin req = 1'b1; wr = 1'b1; addr = REG_BASE + OFS_CTRL;  wdata = {16'h0, ctrl_word(mode_q, wrap_en_q)}; end
            S_POLL_RD:   begin req = 1'b1; addr = REG_BASE + OFS_STATUS; end
            S_RD_PTR:    begin req = 1'b1; addr = REG_BASE + OFS_WPTR; end
            S_RD_LO:     begin req = 1'b1; addr = BASE_ADDR + ram_ofs; end
            S_RD_HI:     begin req = 1'b1; addr = BASE_ADDR + ram_ofs + 32'd4; end
            S_DISABLE:   begin req = 1'b1; wr = 1'b1; addr = REG_BASE + OFS_CTRL; end
            default: ;
        endcase
        out_valid_o = (state_q == S_PUSH);
        busy_o      = (state_q != S_IDLE);
        out_data_o  = {lo_q[47:32], hi_q, lo_q[31:0]};
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mode_q       <= '0;
            wrap_en_q    <= 1'b0;
            addr_start_q <= '0;
            addr_end_q   <= '0;
            stop_pend_q  <= 1'b0;
            wrap_flag_q  <= 1'b0;
            poll_cnt_q   <= '0;
            idx_q        <= '0;
            rem_q        <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            wrapped_o    <= 1'b0;
        end else begin
            done_o     <= 1'b0;
            poll_cnt_q <= (state_q == S_POLL_WAIT) ? poll_cnt_q + 1'b1 : '0;
            if (state_q == S_IDLE && start_i) begin
                mode_q       <= mode_i;
                wrap_en_q    <= wrap_en_i;
                addr_start_q <= addr_start_i;
                addr_end_q   <= addr_end_i;
                stop_pend_q  <= 1'b0;
                wrap_flag_q  <= 1'b0;
                err_o        <= 1'b0;
            end
            if (state_q == S_POLL_RD) begin
                if (stop_i) stop_pend_q <= 1'b1;
                if (ack)    wrap_flag_q <= rdata[3];
            end
            if (state_q == S_RD_PTR && ack) begin
                idx_q <= wrap_flag_q ? rdata[TRACE_WIDTH-1:0] : '0;
                rem_q <= n_entries;
            end
            if (state_q == S_RD_LO && ack) lo_q <= rdata;
            if (state_q == S_RD_HI && ack) hi_q <= rdata[31:0];
            if (state_q == S_PUSH && out_ready_i) begin
                idx_q <= idx_q + 1'b1;
                rem_q <= rem_q - 1'b1;
            end
            if (slverr || tmo) err_o <= 1'b1;
            if (state_q == S_DISABLE && ack && !slverr && !err_o) begin
                done_o    <= 1'b1;
                wrapped_o <= wrap_flag_q;
            end
        end
    end

endmodule

// File: tb/tb_dbg_trace_drain_ctrl.sv
// Scoreboard bench for dbg_trace_drain_ctrl with an APB slave model of the trace unit.
// Define DBG_TRACE_DRAIN_TIMEOUT_EN to also exercise the APB timeout.
module tb_dbg_trace_drain_ctrl;

    localparam logic [31:0] REGB = 32'h0001_0000;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        start_i = 1'b0, stop_i = 1'b0, wrap_en_i = 1'b0;
    logic [2:0]  mode_i = '0;
    logic [31:0] addr_start_i = '0, addr_end_i = '0;
    logic        psel_o, penable_o, pwrite_o;
    logic [31:0] paddr_o;
    logic [47:0] pwdata_o;
    logic [47:0] prdata_i = '0;
    logic        pready_i = 1'b0, pslverr_i = 1'b0;
    logic        out_valid_o, out_ready_i = 1'b1;
    logic [79:0] out_data_o;
    logic        busy_o, done_o, err_o, wrapped_o;

    always #5 clk_i = ~clk_i;

    dbg_trace_drain_ctrl #(
        .BASE_ADDR     (32'h0000_0000),
        .TRACE_WORDS   (8),
        .POLL_INTERVAL (4),
        .APB_TIMEOUT   (255)
    ) dut (
        .clk_i (clk_i), .rstn_i (rstn_i), .start_i (start_i), .stop_i (stop_i),
        .mode_i (mode_i), .wrap_en_i (wrap_en_i), .addr_start_i (addr_start_i),
        .addr_end_i (addr_end_i), .psel_o (psel_o), .penable_o (penable_o),
        .pwrite_o (pwrite_o), .paddr_o (paddr_o), .pwdata_o (pwdata_o),
        .prdata_i (prdata_i), .pready_i (pready_i), .pslverr_i (pslverr_i),
        .out_valid_o (out_valid_o), .out_data_o (out_data_o), .out_ready_i (out_ready_i),
        .busy_o (busy_o), .done_o (done_o), .err_o (err_o), .wrapped_o (wrapped_o)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [47:0] wdata;
    } apb_t;

    apb_t        exp_apb[$];
    logic [79:0] exp_beat[$];
    int vectors = 0, miscompares = 0;
    int done_cnt = 0, apb_cnt = 0;

    logic [2:0] sl_final_status = 3'd3;
    logic       sl_wrap_bit = 1'b0, sl_stuck = 1'b0;
    int         sl_busy_polls = 0, sl_wptr = 0, sl_err_at = 0, sl_ram_rd = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] ram_lo(input int i);
        return {16'hC000 + 16'(i), 32'h1000_0000 + 32'(i)};
    endfunction

    function automatic logic [31:0] ram_hi(input int i);
        return 32'hA000_0000 | (32'(i) << 4);
    endfunction

    function automatic logic [79:0] beat_of(input int i);
        logic [47:0] lo;
        lo = ram_lo(i);
        return {lo[47:32], ram_hi(i), lo[31:0]};
    endfunction

    task automatic exp_w(input logic [31:0] a, input logic [47:0] d);
        apb_t e;
        e.wr = 1'b1; e.addr = a; e.wdata = d;
        exp_apb.push_back(e);
    endtask

    task automatic exp_r(input logic [31:0] a);
        apb_t e;
        e.wr = 1'b0; e.addr = a; e.wdata = '0;
        exp_apb.push_back(e);
    endtask

    task automatic exp_cfg(input logic [2:0] m, input logic w, input logic [31:0] as, input logic [31:0] ae);
        exp_w(REGB + 32'h4, {16'h0, as});
        exp_w(REGB + 32'h8, {16'h0, ae});
        exp_w(REGB, {16'h0, 1'b1, 14'b0, w, 13'b0, m});
    endtask

    task automatic exp_entry(input int i);
        exp_r(32'(i) << 3);
        exp_r((32'(i) << 3) + 32'h4);
        exp_beat.push_back(beat_of(i));
    endtask

    task automatic run_start(input logic [2:0] m, input logic w, input logic [31:0] as, input logic [31:0] ae);
        sl_ram_rd = 0;
        mode_i = m; wrap_en_i = w; addr_start_i = as; addr_end_i = ae;
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy_o && n < 3000) begin
            @(posedge clk_i); #1;
            n++;
        end
        check(name, 80'(busy_o), 80'(0));
        repeat (3) @(posedge clk_i);
        #1;
        check({name, "_apb_left"}, 80'(exp_apb.size()), 80'(0));
        check({name, "_beat_left"}, 80'(exp_beat.size()), 80'(0));
    endtask

    // APB slave model plus transfer scoreboard
    initial begin
        apb_t e;
        forever begin
            @(negedge clk_i);
            if (psel_o && penable_o && !sl_stuck) begin
                pready_i  = 1'b1;
                pslverr_i = 1'b0;
                prdata_i  = '0;
                if (paddr_o >= REGB) begin
                    if (!pwrite_o && paddr_o == REGB + 32'hC) begin
                        if (sl_busy_polls > 0) begin
                            sl_busy_polls--;
                            prdata_i = 48'd2;
                        end else begin
                            prdata_i = {44'h0, sl_wrap_bit, sl_final_status};
                        end
                    end else if (!pwrite_o && paddr_o == REGB + 32'h10) begin
                        prdata_i = 48'(sl_wptr);
                    end
                end else begin
                    sl_ram_rd++;
                    if (sl_ram_rd == sl_err_at) pslverr_i = 1'b1;
                    prdata_i = paddr_o[2] ? {16'h0, ram_hi(int'(paddr_o[5:3]))} : ram_lo(int'(paddr_o[5:3]));
                end
                apb_cnt++;
                check("apb_expected", 80'(exp_apb.size() != 0), 80'(1));
                if (exp_apb.size() != 0) begin
                    e = exp_apb.pop_front();
                    check("apb_wr", 80'(pwrite_o), 80'(e.wr));
                    check("apb_addr", 80'(paddr_o), 80'(e.addr));
                    if (e.wr) check("apb_wdata", 80'(pwdata_o), 80'(e.wdata));
                end
            end else begin
                pready_i  = 1'b0;
                pslverr_i = 1'b0;
            end
        end
    end

    // Stream monitor
    initial begin
        logic [79:0] b;
        forever begin
            @(negedge clk_i);
            if (done_o) done_cnt++;
            if (out_valid_o && out_ready_i) begin
                check("beat_expected", 80'(exp_beat.size() != 0), 80'(1));
                if (exp_beat.size() != 0) begin
                    b = exp_beat.pop_front();
                    check("beat_data", out_data_o, b);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, a0, n;

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_psel", 80'({psel_o, penable_o, pwrite_o}), 80'(0));
        check("rst_paddr", 80'(paddr_o), 80'(0));
        check("rst_pwdata", 80'(pwdata_o), 80'(0));
        check("rst_out", {out_data_o[78:0], out_valid_o}, 80'(0));
        check("rst_status", 80'({busy_o, done_o, err_o, wrapped_o}), 80'(0));
        @(negedge clk_i) rstn_i = 1'b1;

        // Session 1: mode 1, one busy poll, DONE, wptr 3
        sl_busy_polls = 1; sl_final_status = 3'd3; sl_wrap_bit = 1'b0; sl_wptr = 3; sl_err_at = 0;
        exp_cfg(3'd1, 1'b0, 32'h0000_1000, 32'h0000_2000);
        exp_r(REGB + 32'hC); exp_r(REGB + 32'hC); exp_r(REGB + 32'h10);
        for (int i = 0; i < 3; i++) exp_entry(i);
        exp_w(REGB, 48'h0);
        d0 = done_cnt;
        run_start(3'd1, 1'b0, 32'h0000_1000, 32'h0000_2000);
        wait_idle("s1_idle");
        check("s1_done", 80'(done_cnt - d0), 80'(1));
        check("s1_wrapped", 80'(wrapped_o), 80'(0));
        check("s1_err", 80'(err_o), 80'(0));

        // Session 2: wrapped EOB, wptr 5, backpressure with stray start/stop
        sl_busy_polls = 0; sl_final_status = 3'd4; sl_wrap_bit = 1'b1; sl_wptr = 5;
        exp_cfg(3'd0, 1'b1, 32'h8000_0000, 32'h8000_FFFC);
        exp_r(REGB + 32'hC); exp_r(REGB + 32'h10);
        for (int k = 0; k < 8; k++) exp_entry((5 + k) % 8);
        exp_w(REGB, 48'h0);
        d0 = done_cnt;
        out_ready_i = 1'b0;
        run_start(3'd0, 1'b1, 32'h8000_0000, 32'h8000_FFFC);
        n = 0;
        while (!out_valid_o && n < 500) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("bp_valid", 80'(out_valid_o), 80'(1));
        a0 = apb_cnt;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_i); #1;
            start_i = (c == 5);
            stop_i  = (c == 5);
            check("bp_data", out_data_o, (exp_beat.size() != 0) ? exp_beat[0] : '1);
            check("bp_psel", 80'(psel_o), 80'(0));
        end
        start_i = 1'b0; stop_i = 1'b0;
        check("bp_apb_quiet", 80'(apb_cnt - a0), 80'(0));
        out_ready_i = 1'b1;
        wait_idle("s2_idle");
        check("s2_done", 80'(done_cnt - d0), 80'(1));
        check("s2_wrapped", 80'(wrapped_o), 80'(1));

        // Session 3: slave error on the second RAM read
        sl_final_status = 3'd3; sl_wrap_bit = 1'b0; sl_wptr = 4; sl_err_at = 2;
        exp_cfg(3'd2, 1'b0, 32'h1, 32'h2);
        exp_r(REGB + 32'hC); exp_r(REGB + 32'h10);
        exp_r(32'h0); exp_r(32'h4);
        exp_w(REGB, 48'h0);
        d0 = done_cnt;
        run_start(3'd2, 1'b0, 32'h1, 32'h2);
        wait_idle("s3_idle");
        check("s3_err", 80'(err_o), 80'(1));
        check("s3_no_done", 80'(done_cnt - d0), 80'(0));
        check("s3_wrapped_kept", 80'(wrapped_o), 80'(1));

        // Session 4: empty buffer, start clears err
        sl_err_at = 0; sl_wptr = 0;
        exp_cfg(3'd3, 1'b0, 32'h10, 32'h20);
        exp_r(REGB + 32'hC); exp_r(REGB + 32'h10);
        exp_w(REGB, 48'h0);
        d0 = done_cnt;
        run_start(3'd3, 1'b0, 32'h10, 32'h20);
        check("s4_err_clear", 80'(err_o), 80'(0));
        wait_idle("s4_idle");
        check("s4_done", 80'(done_cnt - d0), 80'(1));
        check("s4_wrapped", 80'(wrapped_o), 80'(0));

        // Session 5: stop while waiting to poll, wptr 2
        sl_busy_polls = 100; sl_wptr = 2;
        exp_cfg(3'd5, 1'b0, 32'h100, 32'h200);
        exp_r(REGB + 32'h10);
        exp_entry(0); exp_entry(1);
        exp_w(REGB, 48'h0);
        d0 = done_cnt;
        a0 = apb_cnt;
        run_start(3'd5, 1'b0, 32'h100, 32'h200);
        n = 0;
        while (apb_cnt - a0 < 3 && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("s5_cfg_seen", 80'(apb_cnt - a0), 80'(3));
        stop_i = 1'b1;
        @(posedge clk_i); #1 stop_i = 1'b0;
        wait_idle("s5_idle");
        check("s5_done", 80'(done_cnt - d0), 80'(1));
        sl_busy_polls = 0;

`ifdef DBG_TRACE_DRAIN_TIMEOUT_EN
        // Session 6: slave never ready
        sl_stuck = 1'b1;
        run_start(3'd1, 1'b0, 32'h0, 32'h0);
        repeat (100) @(posedge clk_i);
        #1;
        check("tmo_early_err", 80'(err_o), 80'(0));
        check("tmo_early_busy", 80'(busy_o), 80'(1));
        n = 0;
        while (busy_o && n < 400) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("tmo_idle", 80'(busy_o), 80'(0));
        check("tmo_err", 80'(err_o), 80'(1));
        check("tmo_psel", 80'(psel_o), 80'(0));
        sl_stuck = 1'b0;
`endif

        repeat (5) @(posedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
